// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences the CPU through reset hold, run, and a terminal halt or timeout.
// After system reset the core is held in reset for RESET_HOLD edges. It then
// runs while executed cycles are counted and the instruction address is watched.
// The run ends in HALTED when the PC stalls for STALL_LIMIT equal samples. It
// ends in TIMEOUT when MAX_CYCLES run cycles have elapsed. A halt wins over a
// timeout on the same edge.
// Optional feature macro: CPU_RUN_HALT_ADDR_EN. When this macro is defined,
// reaching HALT_ADDR is an extra halt condition.

module cpu_run_controller #(
    parameter int unsigned              ADDR_WIDTH  = 32,
    parameter int unsigned              RESET_HOLD  = 2,
    parameter int unsigned              STALL_LIMIT = 4,
    parameter int unsigned              MAX_CYCLES  = 1000,
    parameter logic [ADDR_WIDTH-1:0]    HALT_ADDR   = 32'hFFFF_FFFC
) (
    input  logic                    i_clock,
    input  logic                    i_resetn,
    input  logic                    i_clear,
    input  logic [ADDR_WIDTH-1:0]   i_imemAddr,
    output logic                    o_cpuResetn,
    output logic                    o_running,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic [31:0]             o_cycleCount
);

    // The hold counter is kept at least one bit wide so RESET_HOLD=0 still elaborates.
    localparam int unsigned HOLD_W  = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

`ifdef CPU_RUN_HALT_ADDR_EN
    localparam bit HALT_ADDR_EN = 1'b1;
`else
    // The constant-false gate below lets synthesis remove the address comparator.
    localparam bit HALT_ADDR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } run_state_t;

    run_state_t              state;
    run_state_t              state_next;

    logic [HOLD_W-1:0]       hold_cnt;
    logic [STALL_W-1:0]      stall_cnt;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic [31:0]             cycle_count;

    logic                    hold_done;
    logic                    addr_equal;
    logic                    stall_hit;
    logic                    halt_addr_hit;
    logic                    halt;
    logic                    budget_hit;

    logic                    cpu_resetn_next;
    logic                    running_next;
    logic                    done_next;
    logic                    timeout_next;

    assign hold_done     = (hold_cnt == HOLD_W'(RESET_HOLD));
    assign addr_equal    = (i_imemAddr == last_addr);
    assign stall_hit     = addr_equal && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
    assign halt_addr_hit = HALT_ADDR_EN && (i_imemAddr == HALT_ADDR);
    assign halt          = stall_hit || halt_addr_hit;
    assign budget_hit    = (cycle_count == 32'(MAX_CYCLES - 1));

    assign o_cycleCount  = cycle_count;

    // State register.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the output values it implies. A halt takes priority over a timeout.
    always_comb begin
        state_next      = state;
        cpu_resetn_next = 1'b0;
        running_next    = 1'b0;
        done_next       = 1'b0;
        timeout_next    = 1'b0;

        if (i_clear) begin
            state_next = HOLD;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_done) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_next = HALTED;
                    end else if (budget_hit) begin
                        state_next = TIMEOUT;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end

        case (state_next)
            RUN: begin
                cpu_resetn_next = 1'b1;
                running_next    = 1'b1;
            end
            HALTED: begin
                cpu_resetn_next = 1'b1;
                done_next       = 1'b1;
            end
            TIMEOUT: begin
                done_next       = 1'b1;
                timeout_next    = 1'b1;
            end
            default: begin
                cpu_resetn_next = 1'b0;
            end
        endcase
    end

    // Output register: outputs follow the state they belong to on the same edge.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            o_cpuResetn <= 1'b0;
            o_running   <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_cpuResetn <= cpu_resetn_next;
            o_running   <= running_next;
            o_done      <= done_next;
            o_timeout   <= timeout_next;
        end
    end

    // Hold, stall and cycle counters plus the address history; all frozen once terminal.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            last_addr   <= '0;
            cycle_count <= '0;
        end else if (i_clear) begin
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            last_addr   <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                HOLD: begin
                    last_addr <= i_imemAddr;
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    last_addr <= i_imemAddr;
                    if (cycle_count != 32'(MAX_CYCLES)) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                    if (addr_equal) begin
                        if (stall_cnt != STALL_W'(STALL_LIMIT)) begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                default: begin
                    hold_cnt <= hold_cnt;
                end
            endcase
        end
    end

    a_timeout_is_done: assert property (
        @(posedge i_clock) disable iff (!i_resetn) o_timeout |-> o_done
    );

    a_count_bounded: assert property (
        @(posedge i_clock) disable iff (!i_resetn) o_cycleCount <= 32'(MAX_CYCLES)
    );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller.
// Instance a uses MAX_CYCLES=10 and instance b uses MAX_CYCLES=8. Both use
// RESET_HOLD=2 and STALL_LIMIT=4, and the two share all of their stimulus.
// Instance c uses RESET_HOLD=0.

module tb_cpu_run_controller;

    typedef struct packed {
        logic        rn;
        logic        run;
        logic        done;
        logic        to;
        logic [31:0] cnt;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        clr;
        outs_t       exp_a;
        outs_t       exp_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] addr = '0;

    logic        a_rn, a_run, a_done, a_to;
    logic [31:0] a_cnt;
    logic        b_rn, b_run, b_done, b_to;
    logic [31:0] b_cnt;
    logic        c_rn, c_run, c_done, c_to;
    logic [31:0] c_cnt;

    outs_t act_a, act_b, act_c;
    assign act_a = {a_rn, a_run, a_done, a_to, a_cnt};
    assign act_b = {b_rn, b_run, b_done, b_to, b_cnt};
    assign act_c = {c_rn, c_run, c_done, c_to, c_cnt};

    int errors = 0;
    int checks = 0;

    vec_t  vecs[$];
    outs_t sb_a[$];
    outs_t sb_b[$];
    string sb_name[$];

    cpu_run_controller #(
        .ADDR_WIDTH(32), .RESET_HOLD(2), .STALL_LIMIT(4), .MAX_CYCLES(10), .HALT_ADDR(32'hFFFF_FFFC)
    ) u_a (
        .i_clock(clk), .i_resetn(rst_n), .i_clear(clr), .i_imemAddr(addr),
        .o_cpuResetn(a_rn), .o_running(a_run), .o_done(a_done), .o_timeout(a_to), .o_cycleCount(a_cnt)
    );

    cpu_run_controller #(
        .ADDR_WIDTH(32), .RESET_HOLD(2), .STALL_LIMIT(4), .MAX_CYCLES(8), .HALT_ADDR(32'hFFFF_FFFC)
    ) u_b (
        .i_clock(clk), .i_resetn(rst_n), .i_clear(clr), .i_imemAddr(addr),
        .o_cpuResetn(b_rn), .o_running(b_run), .o_done(b_done), .o_timeout(b_to), .o_cycleCount(b_cnt)
    );

    cpu_run_controller #(
        .ADDR_WIDTH(32), .RESET_HOLD(0), .STALL_LIMIT(4), .MAX_CYCLES(1000), .HALT_ADDR(32'hFFFF_FFFC)
    ) u_c (
        .i_clock(clk), .i_resetn(rst_n), .i_clear(clr), .i_imemAddr(addr),
        .o_cpuResetn(c_rn), .o_running(c_run), .o_done(c_done), .o_timeout(c_to), .o_cycleCount(c_cnt)
    );

    always #5 clk = ~clk;

    function automatic outs_t mk(input logic rn, input logic run, input logic done,
                                 input logic to, input int unsigned cnt);
        outs_t o;
        o.rn   = rn;
        o.run  = run;
        o.done = done;
        o.to   = to;
        o.cnt  = cnt;
        return o;
    endfunction

    function automatic outs_t hold_o();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endfunction

    function automatic outs_t run_o(input int unsigned k);
        return mk(1'b1, 1'b1, 1'b0, 1'b0, k);
    endfunction

    function automatic outs_t halt_o(input int unsigned k);
        return mk(1'b1, 1'b0, 1'b1, 1'b0, k);
    endfunction

    function automatic outs_t tmo_o(input int unsigned k);
        return mk(1'b0, 1'b0, 1'b1, 1'b1, k);
    endfunction

    function automatic void add(input string n, input logic [31:0] ad, input logic c,
                                input outs_t ea, input outs_t eb);
        vec_t v;
        v.name  = n;
        v.addr  = ad;
        v.clr   = c;
        v.exp_a = ea;
        v.exp_b = eb;
        vecs.push_back(v);
    endfunction

    // Clear, two hold edges, then the release edge.
    function automatic void add_restart(input string tag);
        add({tag, "_clear"}, 32'h0, 1'b1, hold_o(), hold_o());
        add({tag, "_hold1"}, 32'h0, 1'b0, hold_o(), hold_o());
        add({tag, "_hold2"}, 32'h0, 1'b0, hold_o(), hold_o());
        add({tag, "_release"}, 32'h0, 1'b0, run_o(0), run_o(0));
    endfunction

    task automatic check(input string n, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rn=%0b run=%0b done=%0b to=%0b cnt=%0d, want rn=%0b run=%0b done=%0b to=%0b cnt=%0d",
                     n, act.rn, act.run, act.done, act.to, act.cnt,
                     exp.rn, exp.run, exp.done, exp.to, exp.cnt);
        end
    endtask

    // Drive each row just after an edge, queue its expectation, and compare it after the next edge.
    task automatic run_table();
        outs_t ea, eb;
        string nm;
        for (int i = 0; i < vecs.size(); i++) begin
            addr = vecs[i].addr;
            clr  = vecs[i].clr;
            sb_a.push_back(vecs[i].exp_a);
            sb_b.push_back(vecs[i].exp_b);
            sb_name.push_back(vecs[i].name);
            @(posedge clk);
            #1;
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            nm = sb_name.pop_front();
            check({nm, "_a"}, act_a, ea);
            check({nm, "_b"}, act_b, eb);
        end
        clr = 1'b0;
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] stall_pc [8];
        logic [31:0] pc;
        stall_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC};

        // Reset held low across an edge: everything must read zero.
        @(posedge clk);
        #1;
        check("reset_a", act_a, hold_o());
        check("reset_b", act_b, hold_o());
        check("reset_c", act_c, hold_o());
        rst_n = 1'b1;

        // Hold release: the core stays in reset for two edges and is released on the third.
        add("hold1", 32'h0, 1'b0, hold_o(), hold_o());
        add("hold2", 32'h0, 1'b0, hold_o(), hold_o());
        add("release", 32'h0, 1'b0, run_o(0), run_o(0));

        // Stall halt: the fifth C is the fourth equal sample. For b, that edge also meets its budget, and the halt must win.
        for (int k = 1; k <= 7; k++) begin
            add($sformatf("stall_run%0d", k), stall_pc[k-1], 1'b0, run_o(k), run_o(k));
        end
        add("stall_halt", stall_pc[7], 1'b0, halt_o(8), halt_o(8));
        add("halt_frozen1", 32'h10, 1'b0, halt_o(8), halt_o(8));
        add("halt_frozen2", 32'h14, 1'b0, halt_o(8), halt_o(8));

        // Timeout: the PC advances every cycle.
        add_restart("tmo");
        for (int k = 1; k <= 11; k++) begin
            add($sformatf("tmo_run%0d", k), 32'(4 * (k - 1)), 1'b0,
                (k < 10) ? run_o(k) : tmo_o(10),
                (k < 8)  ? run_o(k) : tmo_o(8));
        end

        // Halt address: the PC reaches FFFF_FFFC on run edge 7.
        add_restart("haddr");
        for (int k = 1; k <= 12; k++) begin
            pc = 32'hFFFF_FFE4 + 32'(4 * (k - 1));
`ifdef CPU_RUN_HALT_ADDR_EN
            add($sformatf("haddr_run%0d", k), pc, 1'b0,
                (k < 7) ? run_o(k) : halt_o(7),
                (k < 7) ? run_o(k) : halt_o(7));
`else
            add($sformatf("haddr_run%0d", k), pc, 1'b0,
                (k < 10) ? run_o(k) : tmo_o(10),
                (k < 8)  ? run_o(k) : tmo_o(8));
`endif
        end

        // Restart, then run two edges so the next reset lands mid-RUN.
        add_restart("pre_rst");
        add("pre_rst_run1", 32'h0, 1'b0, run_o(1), run_o(1));
        add("pre_rst_run2", 32'h4, 1'b0, run_o(2), run_o(2));
        run_table();

        // Asynchronous reset mid-RUN: outputs drop without a clock edge.
        rst_n = 1'b0;
        #1;
        check("async_reset_a", act_a, hold_o());
        check("async_reset_b", act_b, hold_o());
        check("async_reset_c", act_c, hold_o());
        @(posedge clk);
        #1;
        check("reset_held_a", act_a, hold_o());
        addr  = 32'h0;
        rst_n = 1'b1;

        // First edge after release: c (RESET_HOLD=0) is already running.
        @(posedge clk);
        #1;
        check("rh0_release_c", act_c, run_o(0));
        check("rh0_hold_a", act_a, hold_o());

        // A clear while in HOLD restarts the hold count.
        add("clear_in_hold", 32'h0, 1'b1, hold_o(), hold_o());
        add("rehold1", 32'h0, 1'b0, hold_o(), hold_o());
        add("rehold2", 32'h0, 1'b0, hold_o(), hold_o());
        add("re_release", 32'h0, 1'b0, run_o(0), run_o(0));
        add("re_run1", 32'h0, 1'b0, run_o(1), run_o(1));
        run_table();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
